// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath types and widths
package mips_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring divider, signed/unsigned, one quotient bit per clock
module div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [CW-1:0]    count;
  logic             sign_mode;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             take;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // quo_q starts as the dividend magnitude and shifts its bits into the remainder
  always_comb begin
    shifted    = {rem_q, quo_q[WIDTH-1]};
    trial      = {1'b0, shifted} - {2'b00, dvs_mag};
    take       = ~trial[WIDTH+1];
    rem_step   = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step   = {quo_q[WIDTH-2:0], take};
    dvd_mag_in = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag_in = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
    q_fix      = (sign_mode && (dvd_neg ^ dvs_neg)) ? -quo_q : quo_q;
    r_fix      = (sign_mode && dvd_neg) ? -rem_q : rem_q;
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      sign_mode   <= 1'b0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      dvs_zero    <= 1'b0;
      dvs_mag     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            sign_mode <= is_signed;
            dvd_neg   <= is_signed & dividend[WIDTH-1];
            dvs_neg   <= is_signed & divisor[WIDTH-1];
            dvs_zero  <= (divisor == '0);
            dvs_mag   <= dvs_mag_in;
            rem_q     <= '0;
            quo_q     <= dvd_mag_in;
            count     <= CW'(WIDTH);
          end
        end
        RUN: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= r_fix;
          div_by_zero <= dvs_zero;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Truncating division with the architectural divide-by-zero results
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (!s) begin
      if (b == '0) begin q = '1; r = a; end
      else begin q = a / b; r = a % b; end
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) begin
        q = (sa >= 0) ? {W{1'b1}} : W'(1);
        r = a;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
    end
  endfunction

  int           m_cnt = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_z = 1'b0, p_z = 1'b0;

  // m_cnt = edges since acceptance; result lands on edge LAT, done cycle is m_cnt == LAT+1
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_cnt = 1;
        ref_div(is_signed, dividend, divisor, p_q, p_r);
        p_z = (divisor == '0);
      end
    end else if (m_cnt == LAT) begin
      m_q = p_q; m_r = p_r; m_z = p_z;
      m_cnt = LAT + 1;
    end else if (m_cnt == LAT + 1) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", W'(busy), W'(m_cnt >= 1 && m_cnt <= LAT));
      check("done", W'(done), W'(m_cnt == LAT + 1));
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("div_by_zero", W'(div_by_zero), W'(m_z));
    end
  end

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input string tag);
    int n;
    issue(s, a, b);
    wait_done(n);
    check({tag, " latency"}, W'(n), W'(LAT));
    check({tag, " q"}, quotient, eq);
    check({tag, " r"}, remainder, er);
    check({tag, " dbz"}, W'(div_by_zero), W'(ez));
  endtask

  initial begin
    int n, nd;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst busy", W'(busy), '0);
    check("rst done", W'(done), '0);
    check("rst q", quotient, '0);
    check("rst r", remainder, '0);
    check("rst dbz", W'(div_by_zero), '0);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u100/7");
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, "s-100/7");
    run_div(1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, "s100/-7");
    run_div(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, "u/0");
    run_div(1'b1, 32'hFFFFFFFB, 32'd0, 32'd1, 32'hFFFFFFFB, 1'b1, "s-5/0");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, "s ovf");
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, "u big");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, "u max/1");

    // start pulsed mid-run must be dropped, not queued
    issue(1'b0, 32'd100, 32'd7);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      start = (n == 5);
    end
    start = 1'b0;
    check("busy ign latency", W'(n), W'(LAT));
    check("busy ign q", quotient, 32'd14);
    issue(1'b0, 32'd9, 32'd3);
    check("accept after done", W'(busy), W'(1));
    wait_done(n);
    check("b2b latency", W'(n), W'(LAT));
    check("b2b q", quotient, 32'd3);
    check("b2b r", remainder, 32'd0);

    // reset in the middle of a run
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst busy", W'(busy), '0);
    check("midrst done", W'(done), '0);
    check("midrst q", quotient, '0);
    check("midrst r", remainder, '0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("midrst no done", W'(nd), '0);
    run_div(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, "u50/5");

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Sequential integer divider for the MIPS non-pipelined datapath. It performs the inverse of the ALU's single-cycle multiply: it accepts a dividend/divisor pair, runs a radix-2 restoring division one quotient bit per clock, and returns quotient and remainder for the HI/LO registers. It supports signed (DIV) and unsigned (DIVU) modes. The controller holds the instruction while `busy` is high.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a division; sampled only in IDLE.
- `is_signed` in 1: 1 = signed (DIV), 0 = unsigned (DIVU); captured with `start`.
- `dividend` in WIDTH: captured with `start`.
- `divisor` in WIDTH: captured with `start`.
- `busy` out 1: high from the edge after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse; results are valid from this cycle on.
- `quotient` out WIDTH: LO value.
- `remainder` out WIDTH: HI value.
- `div_by_zero` out 1: registered with the results; high if the captured divisor was 0.

## Operation
- States:
  - IDLE → RUN: on `start`=1.
  - RUN → FIX: when the iteration counter reaches 0.
  - FIX → DONE: unconditional.
  - DONE → IDLE: unconditional.
- Capture (IDLE, `start`=1):
  - Latch `is_signed` and the operand signs.
  - Convert both operands to magnitudes. Use two's-complement negation when signed and the MSB is 1. Unsigned operands are used as-is.
  - Clear the partial remainder and load counter = WIDTH.
- RUN, each cycle:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem − divisor_mag, using WIDTH+1 bits.
  - If trial ≥ 0: rem ← trial and set quo LSB to 1. Otherwise restore (quo LSB = 0).
  - Decrement the counter.
- FIX:
  - Signed mode only: negate the quotient if the dividend and divisor signs differ; negate the remainder if the dividend was negative. This gives truncating division; the remainder takes the dividend's sign.
  - Register `quotient`, `remainder` and `div_by_zero`.
- DONE: `done`=1 for this cycle. Outputs hold their values until the next accepted `start`.
- Divisor = 0: no special path; the natural restoring result applies. `div_by_zero`=1.
  - Unsigned: quotient = all ones, remainder = dividend.
  - Signed: quotient = all ones if dividend ≥ 0, else 1; remainder = dividend.
- Signed overflow, −2^(WIDTH−1) / −1: quotient = −2^(WIDTH−1) (wraps), remainder = 0. No flag.
- `start` while not in IDLE is ignored. It is not queued.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `div_by_zero`=0.
  - `quotient`=0, `remainder`=0.
  - Counter = 0.
- `start` is sampled at edge t0. The division runs on edges t1..tWIDTH (RUN). The result is registered at edge tWIDTH+1 (FIX → DONE).
- `done` is high during the cycle following edge tWIDTH+1. For WIDTH=32, that is 33 edges after acceptance.
- `busy` is 1 from t0 until `done` is asserted, and 0 in the `done` cycle. A new `start` is accepted in the cycle after `done`, so the back-to-back issue interval is WIDTH+3 cycles.
- Latency is fixed for every operand value, including divide-by-zero.
- `rst` mid-operation:
  - Next edge forces IDLE and reset values.
  - No `done` is produced and the partial result is discarded.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure
- Shared package `mips_pkg`:
  - `div_state_t` enum (IDLE, RUN, FIX, DONE).
  - `DIV_WIDTH` = 32 constant.
- No sub-module: the restoring step is a few lines inside the FSM datapath.

## Test plan
- Unsigned, 100 / 7: `done` 33 cycles after `start`; quotient=14, remainder=2, `div_by_zero`=0.
- Signed, −100 / 7: quotient=−14 (0xFFFFFFF2), remainder=−2 (0xFFFFFFFE). Also 100 / −7: quotient=−14, remainder=2.
- Divide by zero:
  - Unsigned, 0x12345678 / 0: quotient=0xFFFFFFFF, remainder=0x12345678, `div_by_zero`=1.
  - Signed, −5 / 0: quotient=1, remainder=−5.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Busy handling: pulse `start` again 5 cycles into a 100 / 7 run; that `start` is ignored and exactly one `done` is produced. Then issue `start` in the cycle after `done`; it is accepted and `busy` rises.
- Reset mid-run: assert `rst` at cycle 10 of a division. Required response: next cycle `busy`=0 and outputs are 0, `done` never pulses, and the next division (50 / 5) returns quotient=10, remainder=0.
